// File: rtl/sharp_pkg.sv
// Shared definitions for the sharpness front-end: default widths, the
// coring threshold, the horizontal window FSM states and the sync delay depth.
package sharp_pkg;

    localparam int DW_DEF      = 12;
    localparam int DIFF_W_DEF  = 13;
    localparam int CORE_TH_DEF = 8;

    // Sync outputs trail the inputs by the window fill plus the diff register.
    localparam int SYNC_DLY = 2;

    // Number of pixels currently held in the horizontal window.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } win_state_e;

endpackage

// File: rtl/shp_window_gen_if.sv
// Pixel-stream bundle between the raw video source and the sharpness
// operand generator: incoming sync/de/data and the per-pixel operand set.
interface shp_window_gen_if
    import sharp_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int DIFF_W = DIFF_W_DEF
);

    logic              i_hs;
    logic              i_vs;
    logic              i_de;
    logic [DW-1:0]     i_data;

    logic              shp_en;
    logic [DW-1:0]     shp_curr;
    logic [DIFF_W-1:0] curr_prev_diff;
    logic [DIFF_W-1:0] curr_next_diff;
    logic              shp_sel;
    logic              o_hs;
    logic              o_vs;

    // Source side: drives the raw stream, consumes the operand set.
    modport master (
        output i_hs, i_vs, i_de, i_data,
        input  shp_en, shp_curr, curr_prev_diff, curr_next_diff, shp_sel, o_hs, o_vs
    );

    // Window generator side.
    modport slave (
        input  i_hs, i_vs, i_de, i_data,
        output shp_en, shp_curr, curr_prev_diff, curr_next_diff, shp_sel, o_hs, o_vs
    );

endinterface

// File: rtl/shp_diff_core.sv
// Registered difference / coring stage for a 3-tap window. Given the centre
// pixel and its two neighbours it produces both signed differences and the
// bypass select. Written direction-agnostic so the vertical path can reuse it.
module shp_diff_core
    import sharp_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int DIFF_W  = DIFF_W_DEF,
    parameter int CORE_TH = CORE_TH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic              boundary_i,
    input  logic [DW-1:0]     curr_i,
    input  logic [DW-1:0]     left_i,
    input  logic [DW-1:0]     right_i,
    output logic              en_o,
    output logic [DW-1:0]     curr_o,
    output logic [DIFF_W-1:0] cpd_o,
    output logic [DIFF_W-1:0] cnd_o,
    output logic              sel_o
);

    logic [DIFF_W-1:0] cpd, cnd;
    logic              flat;

    logic              en_q;
    logic [DW-1:0]     curr_q;
    logic [DIFF_W-1:0] cpd_q, cnd_q;
    logic              sel_q;

    // Magnitude of a two's-complement difference; |-4095| still fits.
    function automatic logic [DIFF_W-1:0] mag(input logic [DIFF_W-1:0] d);
        return d[DIFF_W-1] ? -d : d;
    endfunction

    // Zero-extend before subtracting so the result is exact over the full range.
    assign cpd  = DIFF_W'({1'b0, curr_i}) - DIFF_W'({1'b0, left_i});
    assign cnd  = DIFF_W'({1'b0, curr_i}) - DIFF_W'({1'b0, right_i});
    assign flat = (mag(cpd) < DIFF_W'(CORE_TH)) && (mag(cnd) < DIFF_W'(CORE_TH));

    // Capture the operand set on emission; data holds otherwise, only en drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q   <= 1'b0;
            curr_q <= '0;
            cpd_q  <= '0;
            cnd_q  <= '0;
            sel_q  <= 1'b0;
        end else begin
            en_q <= valid_i;
            if (valid_i) begin
                curr_q <= curr_i;
                cpd_q  <= cpd;
                cnd_q  <= cnd;
                sel_q  <= boundary_i | flat;
            end
        end
    end

    assign en_o   = en_q;
    assign curr_o = curr_q;
    assign cpd_o  = cpd_q;
    assign cnd_o  = cnd_q;
    assign sel_o  = sel_q;

endmodule

// File: rtl/shp_window_gen.sv
// Horizontal 3-tap window generator feeding the sharpness stage. Holds the
// previous and current pixel, replicates at both line ends, emits each
// centre pixel once its right neighbour (or the line end) is known, and
// delays the syncs to stay aligned with the emitted pixels.
module shp_window_gen
    import sharp_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int DIFF_W  = DIFF_W_DEF,
    parameter int CORE_TH = CORE_TH_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    shp_window_gen_if.slave bus
);

    win_state_e             state_q;
    logic [DW-1:0]          p_prev_q;
    logic [DW-1:0]          p_curr_q;
    logic [SYNC_DLY-1:0]    hs_dly_q;
    logic [SYNC_DLY-1:0]    vs_dly_q;

    logic                   sync_ok;
    logic                   accept_first;
    logic                   advance;
    logic                   flush;
    logic                   emit;
    logic                   boundary;
    logic [DW-1:0]          p_right;

    // Decode of the current cycle. A falling de always flushes the held
    // centre, even when a sync drops in the same cycle; a sync drop while
    // de is still high is an abort and emits nothing.
    assign sync_ok      = bus.i_hs && bus.i_vs;
    assign accept_first = (state_q == IDLE) && bus.i_de && sync_ok;
    assign advance      = (state_q != IDLE) && bus.i_de && sync_ok;
    assign flush        = (state_q != IDLE) && !bus.i_de;
    assign emit         = advance || flush;
    // The centre held in FILL is the first pixel of its line.
    assign boundary     = flush || (state_q == FILL);
    assign p_right      = flush ? p_curr_q : bus.i_data;

    // Window FSM: state plus the two held pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            p_prev_q <= '0;
            p_curr_q <= '0;
        end else if (advance) begin
            // NOTE: non-blocking, so p_prev_q takes the old p_curr_q.
            p_prev_q <= p_curr_q;
            p_curr_q <= bus.i_data;
            state_q  <= RUN;
        end else if (accept_first) begin
            p_prev_q <= bus.i_data;
            p_curr_q <= bus.i_data;
            state_q  <= FILL;
        end else if (flush || !sync_ok) begin
            p_prev_q <= '0;
            p_curr_q <= '0;
            state_q  <= IDLE;
        end
    end

    // Sync delay line matching the window-plus-register latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_dly_q <= '0;
            vs_dly_q <= '0;
        end else begin
            hs_dly_q <= {hs_dly_q[SYNC_DLY-2:0], bus.i_hs};
            vs_dly_q <= {vs_dly_q[SYNC_DLY-2:0], bus.i_vs};
        end
    end

    assign bus.o_hs = hs_dly_q[SYNC_DLY-1];
    assign bus.o_vs = vs_dly_q[SYNC_DLY-1];

    shp_diff_core #(
        .DW      (DW),
        .DIFF_W  (DIFF_W),
        .CORE_TH (CORE_TH)
    ) u_diff (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (emit),
        .boundary_i (boundary),
        .curr_i     (p_curr_q),
        .left_i     (p_prev_q),
        .right_i    (p_right),
        .en_o       (bus.shp_en),
        .curr_o     (bus.shp_curr),
        .cpd_o      (bus.curr_prev_diff),
        .cnd_o      (bus.curr_next_diff),
        .sel_o      (bus.shp_sel)
    );

endmodule

// File: tb/tb_shp_window_gen.sv
// Bench for shp_window_gen: a table of known lines, hand-written timing,
// abort and reset sequences, then random lines checked against a line-level
// model. Emitted pixels are matched in order against an expectation queue.
module tb_shp_window_gen;
    import sharp_pkg::*;

    localparam int DW     = 12;
    localparam int DIFF_W = 13;
    localparam int CORE   = CORE_TH_DEF;

    typedef struct {
        int curr;
        int cpd;
        int cnd;
        bit sel;
    } exp_t;

    typedef struct {
        int px;
        int curr;
        int cpd;
        int cnd;
        bit sel;
        bit last;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shp_window_gen_if #(.DW(DW), .DIFF_W(DIFF_W)) bus ();

    shp_window_gen #(.DW(DW), .DIFF_W(DIFF_W), .CORE_TH(CORE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    bit   hs_hist[$];
    bit   vs_hist[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Line-level model: every pixel of a completed line is emitted once, in
    // order, with edge replication and boundary/coring bypass.
    function automatic void expect_line(input int px[$]);
        int n = px.size();
        for (int i = 0; i < n; i++) begin
            int   c = px[i];
            int   l = (i == 0) ? c : px[i-1];
            int   r = (i == n - 1) ? c : px[i+1];
            exp_t e;
            e.curr = c;
            e.cpd  = c - l;
            e.cnd  = c - r;
            e.sel  = (i == 0) || (i == n - 1) || (iabs(c - l) < CORE && iabs(c - r) < CORE);
            exp_q.push_back(e);
        end
    endfunction

    // One input cycle: values are set just after an edge, sampled at the next.
    task automatic cyc(input bit de, input bit hs, input bit vs, input int data);
        @(posedge clk);
        #1;
        bus.i_de   = de;
        bus.i_hs   = hs;
        bus.i_vs   = vs;
        bus.i_data = DW'(data);
    endtask

    task automatic send_pixels(input int px[$]);
        foreach (px[i]) cyc(1'b1, 1'b1, 1'b1, px[i]);
    endtask

    // 0: one-cycle de gap; 1: flush then hs blanking; 2: hs falls with de;
    // 3: vs falls with de.
    task automatic end_line(input int mode);
        case (mode)
            0: cyc(1'b0, 1'b1, 1'b1, 0);
            1: begin
                cyc(1'b0, 1'b1, 1'b1, 0);
                cyc(1'b0, 1'b0, 1'b1, 0);
                cyc(1'b0, 1'b0, 1'b1, 0);
                cyc(1'b0, 1'b1, 1'b1, 0);
            end
            2: begin
                cyc(1'b0, 1'b0, 1'b1, 0);
                cyc(1'b0, 1'b0, 1'b1, 0);
                cyc(1'b0, 1'b1, 1'b1, 0);
            end
            default: begin
                cyc(1'b0, 1'b1, 1'b0, 0);
                cyc(1'b0, 1'b0, 1'b0, 0);
                cyc(1'b0, 1'b1, 1'b1, 0);
            end
        endcase
    endtask

    task automatic drain_and_check(input string name);
        repeat (3) cyc(1'b0, 1'b1, 1'b1, 0);
        @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " shp_en"},   int'(bus.shp_en), 0);
        check({tag, " shp_curr"}, int'(bus.shp_curr), 0);
        check({tag, " cpd"},      int'(bus.curr_prev_diff), 0);
        check({tag, " cnd"},      int'(bus.curr_next_diff), 0);
        check({tag, " shp_sel"},  int'(bus.shp_sel), 0);
        check({tag, " o_hs"},     int'(bus.o_hs), 0);
        check({tag, " o_vs"},     int'(bus.o_vs), 0);
    endtask

    // Emission scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.shp_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected shp_en", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("shp_curr", int'(bus.shp_curr), mon_e.curr);
                check("curr_prev_diff", int'($signed(bus.curr_prev_diff)), mon_e.cpd);
                check("curr_next_diff", int'($signed(bus.curr_next_diff)), mon_e.cnd);
                check("shp_sel", int'(bus.shp_sel), int'(mon_e.sel));
            end
        end
    end

    // Sync history as sampled at each active edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            hs_hist.delete();
            vs_hist.delete();
        end else begin
            hs_hist.push_back(bus.i_hs);
            vs_hist.push_back(bus.i_vs);
            if (hs_hist.size() > 4) begin
                void'(hs_hist.pop_front());
                void'(vs_hist.pop_front());
            end
        end
    end

    // Outputs seen after edge k reflect the syncs sampled at edge k-1.
    always @(negedge clk) begin
        if (rst_n && hs_hist.size() >= 2) begin
            check("o_hs delay", int'(bus.o_hs), int'(hs_hist[hs_hist.size()-2]));
            check("o_vs delay", int'(bus.o_vs), int'(vs_hist[vs_hist.size()-2]));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[11];
        int   q[$];
        exp_t e;

        vecs = '{
            '{ 100,  100,     0,  -100, 1'b1, 1'b0},
            '{ 200,  200,   100,    50, 1'b0, 1'b0},
            '{ 150,  150,   -50,     0, 1'b1, 1'b1},
            '{ 500,  500,     0,    -3, 1'b1, 1'b0},
            '{ 503,  503,     3,    -2, 1'b1, 1'b0},
            '{ 505,  505,     2,     1, 1'b1, 1'b0},
            '{ 504,  504,    -1,     0, 1'b1, 1'b1},
            '{4095, 4095,     0,     0, 1'b1, 1'b1},
            '{   0,    0,     0, -4095, 1'b1, 1'b0},
            '{4095, 4095,  4095,  4095, 1'b0, 1'b0},
            '{   0,    0, -4095,     0, 1'b1, 1'b1}
        };

        bus.i_de   = 1'b0;
        bus.i_hs   = 1'b1;
        bus.i_vs   = 1'b1;
        bus.i_data = '0;

        // Reset state.
        #3;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Known lines from the table.
        for (int i = 0; i < 11; i++) begin
            e.curr = vecs[i].curr;
            e.cpd  = vecs[i].cpd;
            e.cnd  = vecs[i].cnd;
            e.sel  = vecs[i].sel;
            exp_q.push_back(e);
            cyc(1'b1, 1'b1, 1'b1, vecs[i].px);
            if (vecs[i].last) end_line(1);
        end
        drain_and_check("table pending");

        // Latency: centre emitted after its right neighbour is accepted,
        // last pixel one cycle later after the flush.
        q = '{100, 200, 150};
        expect_line(q);
        cyc(1'b1, 1'b1, 1'b1, 100);
        cyc(1'b1, 1'b1, 1'b1, 200);
        cyc(1'b1, 1'b1, 1'b1, 150);
        cyc(1'b0, 1'b1, 1'b1, 0);      // returns just after 150 is accepted
        @(negedge clk);
        check("lat en after 150 acc", int'(bus.shp_en), 1);
        check("lat curr after 150 acc", int'(bus.shp_curr), 200);
        @(negedge clk);
        check("lat en at flush", int'(bus.shp_en), 1);
        check("lat curr at flush", int'(bus.shp_curr), 150);
        @(negedge clk);
        check("lat en after flush", int'(bus.shp_en), 0);
        check("lat curr held", int'(bus.shp_curr), 150);
        drain_and_check("latency pending");

        // Mid-line abort: only the first pixel was emitted before vs fell.
        e.curr = 300; e.cpd = 0; e.cnd = -400; e.sel = 1'b1;
        exp_q.push_back(e);
        cyc(1'b1, 1'b1, 1'b1, 300);
        cyc(1'b1, 1'b1, 1'b1, 700);
        cyc(1'b1, 1'b1, 1'b0, 999);
        cyc(1'b0, 1'b1, 1'b0, 0);
        cyc(1'b0, 1'b1, 1'b0, 0);
        cyc(1'b0, 1'b1, 1'b1, 0);
        q = '{50, 60};
        expect_line(q);
        send_pixels(q);
        end_line(1);
        drain_and_check("abort pending");

        // Asynchronous reset while the window is running.
        q = '{1000, 1234, 2000, 3000};
        expect_line(q);
        send_pixels(q);
        @(negedge clk);                // 1234 on outputs now
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async rst");
        exp_q.delete();
        bus.i_de = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        q = '{10, 900, 20};
        expect_line(q);
        send_pixels(q);
        end_line(1);
        drain_and_check("post-reset pending");

        // Random lines against the model.
        for (int ln = 0; ln < 40; ln++) begin
            int n    = $urandom_range(1, 16);
            int base = $urandom_range(0, 4095);
            int v;
            q.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    v = base + int'($urandom_range(0, 14)) - 7;
                    if (v < 0) v = 0;
                    if (v > 4095) v = 4095;
                end else begin
                    v = $urandom_range(0, 4095);
                end
                base = v;
                q.push_back(v);
            end
            expect_line(q);
            send_pixels(q);
            end_line($urandom_range(0, 3));
        end
        drain_and_check("random pending");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shp_window_gen.md
Name: shp_window_gen

Overview:
- Upstream neighbour of the sharpness stage. Converts a raw 12-bit pixel stream into the per-pixel operand set that stage consumes.
- Builds a 3-tap horizontal window (prev/curr/next) with edge replication at line ends.
- Per pixel it emits the centre pixel, the signed differences curr−prev and curr−next, a bypass select (line boundary or coring), and a qualifying enable.
- Sync signals are delayed so they stay aligned with the emitted pixels.

Parameters:
- DW, 12, pixel width.
- DIFF_W, 13, signed difference width (DW+1).
- CORE_TH, 8, coring threshold. Pixel is bypassed when both |diffs| < CORE_TH.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- i_hs  in  1  line sync, active-low blanking (low = blank)
- i_vs  in  1  frame sync, active-low blanking
- i_de  in  1  input pixel valid
- i_data  in  DW  input pixel
- shp_en  out  1  output pixel valid
- shp_curr  out  DW  centre pixel
- curr_prev_diff  out  DIFF_W  curr−prev, two's complement
- curr_next_diff  out  DIFF_W  curr−next, two's complement
- shp_sel  out  1  1 = bypass sharpening for this pixel
- o_hs  out  1  i_hs delayed 2 cycles
- o_vs  out  1  i_vs delayed 2 cycles

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0, including o_hs and o_vs.
  - State = IDLE; window registers p_prev, p_curr, p_new = 0.
- All outputs are registered.
- States:
  - IDLE: no pixel held.
  - FILL: one pixel held.
  - RUN: two pixels held.
- Transitions:
  - IDLE, i_de=1: p_curr<=i_data, p_prev<=i_data (left replication), go FILL.
  - FILL or RUN, i_de=1: window advances and the held centre is emitted next cycle with next=i_data. p_prev<=p_curr, p_curr<=i_data. Go/stay RUN.
  - FILL or RUN, i_de=0: flush. Held centre is emitted with next=curr (right replication), go IDLE. Flush happens even if i_hs/i_vs fall in the same cycle.
  - IDLE with i_hs=0 or i_vs=0: stays IDLE, window cleared to 0.
  - i_vs=0 or i_hs=0 while i_de=1 (mid-line abort): no emission this cycle, go IDLE, window cleared.
- Emission cycle N (held centre C, left L, right R); values appear on outputs at N+1:
  - shp_en=1, shp_curr=C.
  - curr_prev_diff = {0,C} − {0,L}; curr_next_diff = {0,C} − {0,R}. DIFF_W-bit exact, no saturation.
  - shp_sel=1 if C is the first pixel of the line, or the last pixel (flush), or (|C−L|<CORE_TH and |C−R|<CORE_TH).
- Non-emission cycles: shp_en=0, other data outputs hold their previous values.
- Latency:
  - Pixel k (k < last) is emitted 1 cycle after pixel k+1 is accepted.
  - The last pixel is emitted 2 cycles after its acceptance.
- o_hs/o_vs: 2-stage shift of i_hs/i_vs. Sync must fall no earlier than the cycle i_de falls; the last pixel then precedes the o_hs fall.
- Single-pixel line: FILL→flush. Both diffs = 0, shp_sel=1.
- Back-to-back lines with a 1-cycle de gap: flush cycle and IDLE acceptance do not overlap. The next line's first pixel is accepted when de rises again.
- A 1-cycle de gap mid-line is treated as a line end (flush). Upstream guarantees contiguous de within a line.

Decomposition:
- Package sharp_pkg:
  - DW, DIFF_W, CORE_TH defaults.
  - State enum {IDLE, FILL, RUN}.
  - Sync delay depth constant = 2.
- Sub-module shp_diff_core:
  - Registered diff, abs and coring compare (inputs C/L/R, boundary flag).
  - Reused by the vertical path later.
- FSM, window and sync delay stay in the top module.

Test Plan:
- Line 100,200,150 (de 3 cycles, then low) -> three shp_en pulses:
  - (100, 0, −100, sel=1)
  - (200, 100, 50, sel=0)
  - (150, −50, 0, sel=1)
  - The last pulse lands 2 cycles after pixel 150 is accepted.
- Flat line 500,503,505,504 -> middle pixels have |diffs|<8, so sel=1 on every pixel.
- Single pixel 4095 -> one pulse: curr=4095, diffs 0, sel=1.
- Extremes 0,4095,0 -> middle pixel: curr_prev_diff=+4095, curr_next_diff=+4095 (13'h0FFF). Edges: −4095 (13'h1001).
- Abort: i_vs low while de high after 2 pixels -> no further shp_en that line. Next line starts clean with first-pixel sel=1.
- Assert rst_n low mid-RUN -> all outputs 0 immediately (asynchronous). After release, the first pixel is treated as a line start.
